instruction_fetch_unit: RTL and testbench

- Owns the program counter and instruction register for the multicycle computer.
- Issues reads to the 27-bit instruction memory (14-bit bus address, bit 13 = instruction-memory chip select, one-cycle registered read latency).
- Captures the returned word, splits it into fields and presents it to the control unit with a valid/ack handshake.
- Accepts PC loads from the branch path (bleq) and from the boot sequence.

---
 rtl/cpu_pkg.sv | 46 ++++
 rtl/instr_field_decode.sv | 22 ++
 rtl/instruction_fetch_unit.sv | 181 ++++++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle computer: word geometry, instruction
// field positions, opcode values and the fetch state encoding.
// Optional build macro: ILLEGAL_OPCODE_TRAP_EN adds the HALT fetch state.
package cpu_pkg;

    localparam int INSTR_WIDTH = 27;
    localparam int PC_WIDTH    = 13;
    localparam int IMEM_CS_BIT = 13;

    // Instruction field bit positions
    localparam int OPCODE_MSB = 26;
    localparam int OPCODE_LSB = 23;
    localparam int RD_MSB     = 22;
    localparam int RD_LSB     = 18;
    localparam int RS_MSB     = 17;
    localparam int RS_LSB     = 13;
    localparam int RT_MSB     = 12;
    localparam int RT_LSB     = 8;
    localparam int IMM_MSB    = 7;
    localparam int IMM_LSB    = 0;

    // Opcodes implemented by the machine
    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_ADDI = 4'd2;
    localparam logic [3:0] OP_LI   = 4'd3;
    localparam logic [3:0] OP_BLEQ = 4'd4;
    localparam logic [3:0] OP_LW   = 4'd5;
    localparam logic [3:0] OP_SW   = 4'd6;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_DONE    = 3'd3
`ifdef ILLEGAL_OPCODE_TRAP_EN
        ,
        ST_HALT    = 3'd4
`endif
    } fetch_state_t;

    function automatic logic opcode_is_legal(input logic [3:0] op);
        return op inside {OP_NOP, OP_ADD, OP_ADDI, OP_LI, OP_BLEQ, OP_LW, OP_SW};
    endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Combinational split of an instruction word into its fields, plus the
// legal-opcode check. Shared with the control unit.
module instr_field_decode
    import cpu_pkg::*;
(
    input  logic [INSTR_WIDTH-1:0] i_instr,
    output logic [3:0]             o_opcode,
    output logic [4:0]             o_rd,
    output logic [4:0]             o_rs,
    output logic [4:0]             o_rt,
    output logic [7:0]             o_imm,
    output logic                   o_legal
);

    assign o_opcode = i_instr[OPCODE_MSB:OPCODE_LSB];
    assign o_rd     = i_instr[RD_MSB:RD_LSB];
    assign o_rs     = i_instr[RS_MSB:RS_LSB];
    assign o_rt     = i_instr[RT_MSB:RT_LSB];
    assign o_imm    = i_instr[IMM_MSB:IMM_LSB];
    assign o_legal  = opcode_is_legal(o_opcode);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns PC and instruction register, reads the
// instruction memory (one-cycle registered latency) and hands the word to
// the control unit with a valid/ack handshake.
// Optional build macro: ILLEGAL_OPCODE_TRAP_EN adds illegal_instr and a
// terminal HALT state entered when an undefined opcode is fetched.
module instruction_fetch_unit #(
    parameter int                        INSTR_WIDTH = cpu_pkg::INSTR_WIDTH,
    parameter int                        PC_WIDTH    = cpu_pkg::PC_WIDTH,
    parameter logic [cpu_pkg::PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   fetch_req,
    input  logic                   instr_ack,
    input  logic                   pc_load,
    input  logic [PC_WIDTH-1:0]    pc_load_value,
    output logic                   mem_read_enable,
    output logic [PC_WIDTH:0]      mem_address,
    input  logic [INSTR_WIDTH-1:0] mem_read_data,
    output logic [PC_WIDTH-1:0]    pc,
    output logic                   instr_valid,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [3:0]             opcode,
    output logic [4:0]             rd,
    output logic [4:0]             rs,
    output logic [4:0]             rt,
    output logic [7:0]             imm,
    output logic                   busy
`ifdef ILLEGAL_OPCODE_TRAP_EN
    ,
    output logic                   illegal_instr
`endif
);

    import cpu_pkg::*;

    fetch_state_t           r_state;
    fetch_state_t           w_state_next;
    logic [PC_WIDTH-1:0]    r_pc;
    logic [PC_WIDTH-1:0]    r_pending_value;
    logic                   r_pending_load;
    logic [INSTR_WIDTH-1:0] r_instr;
    logic                   r_mem_re;
    logic [PC_WIDTH:0]      r_mem_addr;
    logic [PC_WIDTH:0]      w_fetch_addr;
    // Legality of the latched word is consumed by the control unit, not here
    logic                   w_ir_legal_unused;
`ifdef ILLEGAL_OPCODE_TRAP_EN
    logic                   r_illegal;
    logic                   w_trap;
`endif

    // Bus address of the current PC with the instruction-memory chip select set
    always_comb begin
        w_fetch_addr              = {1'b0, r_pc};
        w_fetch_addr[IMEM_CS_BIT] = 1'b1;
    end

`ifdef ILLEGAL_OPCODE_TRAP_EN
    assign w_trap = !opcode_is_legal(mem_read_data[OPCODE_MSB:OPCODE_LSB]);
`endif

    // Fetch state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a PC load in IDLE wins over a fetch request
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!pc_load && fetch_req) begin
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_state_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
`ifdef ILLEGAL_OPCODE_TRAP_EN
                w_state_next = w_trap ? ST_HALT : ST_DONE;
`else
                w_state_next = ST_DONE;
`endif
            end
            ST_DONE: begin
                if (instr_ack) begin
                    w_state_next = ST_IDLE;
                end
            end
`ifdef ILLEGAL_OPCODE_TRAP_EN
            ST_HALT: begin
                w_state_next = ST_HALT;
            end
`endif
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // PC, deferred PC load, instruction register and memory request registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc            <= RESET_PC;
            r_pending_load  <= 1'b0;
            r_pending_value <= '0;
            r_instr         <= '0;
            r_mem_re        <= 1'b0;
            r_mem_addr      <= '0;
        end else begin
            // Read strobe is high exactly while the state is ISSUE
            r_mem_re <= (w_state_next == ST_ISSUE);
            if (w_state_next == ST_ISSUE) begin
                r_mem_addr <= w_fetch_addr;
            end
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (pc_load) begin
                        r_pc <= pc_load_value;
                    end
                end
                ST_ISSUE: begin
                    // Read already uses the old PC; remember the load for CAPTURE
                    if (pc_load) begin
                        r_pending_load  <= 1'b1;
                        r_pending_value <= pc_load_value;
                    end
                end
                ST_CAPTURE: begin
                    r_instr        <= mem_read_data;
                    r_pending_load <= 1'b0;
                    if (pc_load) begin
                        r_pc <= pc_load_value;
                    end else if (r_pending_load) begin
                        r_pc <= r_pending_value;
                    end else begin
                        r_pc <= r_pc + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef ILLEGAL_OPCODE_TRAP_EN
    // Sticky trap flag; only reset clears it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_illegal <= 1'b0;
        end else if (r_state == ST_CAPTURE && w_trap) begin
            r_illegal <= 1'b1;
        end
    end
    assign illegal_instr = r_illegal;
`endif

    instr_field_decode u_decode (
        .i_instr  (r_instr),
        .o_opcode (opcode),
        .o_rd     (rd),
        .o_rs     (rs),
        .o_rt     (rt),
        .o_imm    (imm),
        .o_legal  (w_ir_legal_unused)
    );

    assign mem_read_enable = r_mem_re;
    assign mem_address     = r_mem_addr;
    assign pc              = r_pc;
    assign instr           = r_instr;
    assign instr_valid     = (r_state == ST_DONE);
    assign busy            = (r_state == ST_ISSUE) || (r_state == ST_CAPTURE);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a one-cycle-latency
// instruction memory model. Define ILLEGAL_OPCODE_TRAP_EN to cover the trap.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        fetch_req = 1'b0;
    logic        instr_ack = 1'b0;
    logic        pc_load = 1'b0;
    logic [12:0] pc_load_value = '0;
    logic        mem_read_enable;
    logic [13:0] mem_address;
    logic [26:0] mem_read_data = '0;
    logic [12:0] pc;
    logic        instr_valid;
    logic [26:0] instr;
    logic [3:0]  opcode;
    logic [4:0]  rd, rs, rt;
    logic [7:0]  imm;
    logic        busy;
`ifdef ILLEGAL_OPCODE_TRAP_EN
    logic        illegal_instr;
`endif

    int          n_checks = 0;
    int          n_fail = 0;
    logic        force_illegal = 1'b0;
    logic [13:0] rd_log[$];

    instruction_fetch_unit dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .fetch_req       (fetch_req),
        .instr_ack       (instr_ack),
        .pc_load         (pc_load),
        .pc_load_value   (pc_load_value),
        .mem_read_enable (mem_read_enable),
        .mem_address     (mem_address),
        .mem_read_data   (mem_read_data),
        .pc              (pc),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .opcode          (opcode),
        .rd              (rd),
        .rs              (rs),
        .rt              (rt),
        .imm             (imm),
        .busy            (busy)
`ifdef ILLEGAL_OPCODE_TRAP_EN
        ,
        .illegal_instr   (illegal_instr)
`endif
    );

    always #5 clk = ~clk;

    // Memory contents: fixed word at 0x2000, otherwise derived from the address
    function automatic logic [26:0] mem_word(input logic [13:0] a);
        logic [3:0] op;
        if (a == 14'h2000) return 27'h2800010;
        op = (a[2:0] == 3'd7) ? 4'd6 : {1'b0, a[2:0]};
        return {op, a[12:0], a[9:0] ^ 10'h2A5};
    endfunction

    // Instruction memory model with one-cycle registered read
    always @(posedge clk) begin
        if (mem_read_enable) begin
            mem_read_data <= force_illegal ? {4'hF, 23'h0} : mem_word(mem_address);
            rd_log.push_back(mem_address);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic preset_pc(input logic [12:0] v);
        pc_load = 1'b1;
        pc_load_value = v;
        tick();
        pc_load = 1'b0;
        chk("preset pc", pc, v);
    endtask

    // One fetch from IDLE; stage: 0 none, 1 load in ISSUE, 2 load in CAPTURE, 3 both
    task automatic fetch(input string tag, input logic [13:0] exp_addr, input int stage,
                         input logic [12:0] v1, input logic [12:0] v2, input logic [12:0] exp_pc);
        int n0;
        n0 = rd_log.size();
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        chk({tag, " issue re"}, mem_read_enable, 1);
        chk({tag, " issue addr"}, mem_address, exp_addr);
        chk({tag, " issue busy"}, busy, 1);
        if (stage == 1 || stage == 3) begin
            pc_load = 1'b1;
            pc_load_value = v1;
        end
        tick();
        pc_load = 1'b0;
        chk({tag, " capture re"}, mem_read_enable, 0);
        chk({tag, " capture valid"}, instr_valid, 0);
        if (stage == 2 || stage == 3) begin
            pc_load = 1'b1;
            pc_load_value = (stage == 3) ? v2 : v1;
        end
        tick();
        pc_load = 1'b0;
        chk({tag, " valid"}, instr_valid, 1);
        chk({tag, " instr"}, instr, mem_word(exp_addr));
        chk({tag, " pc"}, pc, exp_pc);
        chk({tag, " reads"}, rd_log.size(), n0 + 1);
        if (rd_log.size() > 0) chk({tag, " read addr"}, rd_log[rd_log.size()-1], exp_addr);
        instr_ack = 1'b1;
        tick();
        instr_ack = 1'b0;
        chk({tag, " ack valid"}, instr_valid, 0);
    endtask

    typedef struct {
        logic        preset;
        logic [12:0] start;
        int          stage;
        logic [12:0] v1;
        logic [12:0] v2;
        logic [13:0] addr;
        logic [12:0] pc_after;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int n0;

        vecs[0] = '{1'b1, 13'h0009, 1, 13'h0007, 13'h0000, 14'h2009, 13'h0007};
        vecs[1] = '{1'b0, 13'h0000, 0, 13'h0000, 13'h0000, 14'h2007, 13'h0008};
        vecs[2] = '{1'b1, 13'h1FFE, 0, 13'h0000, 13'h0000, 14'h3FFE, 13'h1FFF};
        vecs[3] = '{1'b0, 13'h0000, 0, 13'h0000, 13'h0000, 14'h3FFF, 13'h0000};
        vecs[4] = '{1'b1, 13'h0100, 2, 13'h00AA, 13'h0000, 14'h2100, 13'h00AA};
        vecs[5] = '{1'b1, 13'h0200, 3, 13'h0003, 13'h0044, 14'h2200, 13'h0044};
        vecs[6] = '{1'b1, 13'h0300, 1, 13'h0011, 13'h0022, 14'h2300, 13'h0011};

        // Reset values
        tick();
        tick();
        chk("rst pc", pc, 0);
        chk("rst instr", instr, 0);
        chk("rst valid", instr_valid, 0);
        chk("rst re", mem_read_enable, 0);
        chk("rst addr", mem_address, 0);
        chk("rst busy", busy, 0);
        reset_n = 1'b1;
        tick();

        // First fetch: latency and field split
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        chk("first re", mem_read_enable, 1);
        chk("first addr", mem_address, 14'h2000);
        chk("first valid N+1", instr_valid, 0);
        tick();
        chk("first re pulse", mem_read_enable, 0);
        chk("first valid N+2", instr_valid, 0);
        tick();
        chk("first valid N+3", instr_valid, 1);
        chk("first instr", instr, 27'h2800010);
        chk("first opcode", opcode, 5);
        chk("first rd", rd, 0);
        chk("first imm", imm, 8'h10);
        chk("first pc", pc, 1);
        instr_ack = 1'b1;
        tick();
        instr_ack = 1'b0;

        // Back-to-back fetches with fetch_req held
        preset_pc(13'h0000);
        rd_log.delete();
        fetch_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc = 0;
            while (!instr_valid && cyc < 10) begin
                tick();
                cyc++;
            end
            chk("b2b valid", instr_valid, 1);
            tick();
            chk("b2b held in done", instr_valid, 1);
            instr_ack = 1'b1;
            tick();
            instr_ack = 1'b0;
            if (k == 2) fetch_req = 1'b0;
        end
        tick();
        tick();
        chk("b2b reads", rd_log.size(), 3);
        for (int k = 0; k < 3 && k < rd_log.size(); k++) begin
            chk("b2b addr", rd_log[k], 14'h2000 + 14'(k));
        end
        chk("b2b pc", pc, 3);

        // Table-driven fetches with PC loads at various stages
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].preset) preset_pc(vecs[i].start);
            fetch($sformatf("vec%0d", i), vecs[i].addr, vecs[i].stage,
                  vecs[i].v1, vecs[i].v2, vecs[i].pc_after);
        end

        // pc_load and fetch_req together in IDLE: load wins, no read
        n0 = rd_log.size();
        pc_load = 1'b1;
        pc_load_value = 13'h1FFF;
        fetch_req = 1'b1;
        tick();
        pc_load = 1'b0;
        fetch_req = 1'b0;
        chk("idle load pc", pc, 13'h1FFF);
        chk("idle load re", mem_read_enable, 0);
        chk("idle load busy", busy, 0);
        tick();
        chk("idle load no read", rd_log.size(), n0);
        fetch("wrap", 14'h3FFF, 0, 13'h0, 13'h0, 13'h0000);

        // instr_ack outside DONE ignored; pc_load in DONE takes effect at once
        fetch_req = 1'b1;
        instr_ack = 1'b1;
        tick();
        fetch_req = 1'b0;
        tick();
        tick();
        instr_ack = 1'b0;
        chk("early ack valid", instr_valid, 1);
        chk("early ack pc", pc, 1);
        pc_load = 1'b1;
        pc_load_value = 13'h0123;
        tick();
        pc_load = 1'b0;
        chk("done load pc", pc, 13'h0123);
        chk("done load valid", instr_valid, 1);
        instr_ack = 1'b1;
        tick();
        instr_ack = 1'b0;

        // Asynchronous reset in the middle of CAPTURE
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        tick();
        chk("pre-reset busy", busy, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async rst pc", pc, 0);
        chk("async rst instr", instr, 0);
        chk("async rst valid", instr_valid, 0);
        chk("async rst re", mem_read_enable, 0);
        chk("async rst addr", mem_address, 0);
        chk("async rst busy", busy, 0);
        tick();
        reset_n = 1'b1;
        tick();
        fetch("post-reset", 14'h2000, 0, 13'h0, 13'h0, 13'h0001);

        // Undefined opcode from memory
        preset_pc(13'h0050);
        force_illegal = 1'b1;
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        tick();
        tick();
`ifdef ILLEGAL_OPCODE_TRAP_EN
        chk("trap flag", illegal_instr, 1);
        chk("trap valid", instr_valid, 0);
        chk("trap busy", busy, 0);
        chk("trap pc", pc, 13'h0051);
        n0 = rd_log.size();
        fetch_req = 1'b1;
        instr_ack = 1'b1;
        pc_load = 1'b1;
        pc_load_value = 13'h0007;
        cyc = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (mem_read_enable) cyc++;
        end
        fetch_req = 1'b0;
        instr_ack = 1'b0;
        pc_load = 1'b0;
        chk("halt no re", cyc, 0);
        chk("halt no read", rd_log.size(), n0);
        chk("halt pc", pc, 13'h0051);
        chk("halt flag", illegal_instr, 1);
        chk("halt valid", instr_valid, 0);
`else
        chk("passthru valid", instr_valid, 1);
        chk("passthru opcode", opcode, 4'hF);
        chk("passthru pc", pc, 13'h0051);
        instr_ack = 1'b1;
        tick();
        instr_ack = 1'b0;
`endif
        force_illegal = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
